ram_port_arbiter: RTL and testbench

- Time-shares port A of the 64 KB system dpram between the 6502 (gated by cpu_clken) and the ESP32 SPI loader.
- Replaces the static halt-only mux: the SPI loader can read and write RAM while the CPU runs, using the idle cycles between CPU strobes.
- When halt is high, the SPI loader owns every cycle. Port B (video) is not touched.

---
 rtl/vic20_pkg.sv | 23 ++
 rtl/req_latch.sv | 69 ++++++
 rtl/ram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vic20_pkg.sv
// Shared types and constants for the VIC-20 RAM port A arbiter.
// Holds the arbiter state encoding, default bus widths and err bit positions.
package vic20_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam int ERR_CPU_OVR  = 1;
    localparam int ERR_SPI_DROP = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_CPU_CAP,
        ST_SPI_ACC,
        ST_SPI_CAP
    } arb_state_t;

    function automatic logic is_dispatch_state(input arb_state_t st);
        return (st == ST_IDLE) || (st == ST_CPU_CAP) || (st == ST_SPI_CAP);
    endfunction

endpackage

// File: rtl/req_latch.sv
// Single-entry request latch: pending flag plus holding registers.
// A request arriving while the entry is occupied is reported on drop_o and discarded.
module req_latch
    import vic20_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              clr_i,
    output logic              pend_o,
    output logic              take_o,
    output logic              drop_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              pend_q, pend_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              free;

    // The entry frees in its completion cycle, so a request landing there is accepted.
    assign free   = ~pend_q | clr_i;
    assign take_o = req_i & free;
    assign drop_o = req_i & ~free;

    always_comb begin
        pend_d  = pend_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (take_o) begin
            pend_d  = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end else if (clr_i) begin
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pend_o  = pend_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Time-shares dpram port A between the 6502 (cpu_clken slots) and the SPI loader.
// Define RAM_WP_EN to block CPU writes at or above WP_BASE.
module ram_port_arbiter
    import vic20_pkg::*;
#(
    parameter int              ADDR_W  = ADDR_W_DEF,
    parameter int              DATA_W  = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] WP_BASE = 16'hC000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_clken,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              halt,
    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_busy,
    output logic              spi_ack,
    output logic [DATA_W-1:0] spi_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [1:0]        err
);

    arb_state_t        state_q, state_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] spi_rdata_q;
    logic [1:0]        err_q, err_d;

    logic              spi_pend, spi_take, spi_drop, spi_clr;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;

    logic              cpu_set, cpu_ovr, cpu_go, spi_go, wp_hit;

`ifdef RAM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    assign wp_hit = WP_ON && (cpu_addr >= WP_BASE);

    req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_spi_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (spi_req),
        .we_i    (spi_we),
        .addr_i  (spi_addr),
        .wdata_i (spi_wdata),
        .clr_i   (spi_clr),
        .pend_o  (spi_pend),
        .take_o  (spi_take),
        .drop_o  (spi_drop),
        .we_o    (h_we),
        .addr_o  (h_addr),
        .wdata_o (h_wdata)
    );

    // Requests arriving this cycle count as pending so an idle arbiter starts next cycle.
    assign spi_clr = (state_q == ST_SPI_CAP);
    assign cpu_set = cpu_clken & ~halt;
    assign cpu_ovr = cpu_set & cpu_pend_q;
    assign cpu_go  = cpu_pend_q | cpu_set;
    assign spi_go  = (spi_pend & ~spi_clr) | spi_take;

    always_comb begin
        state_d    = state_q;
        cpu_pend_d = cpu_pend_q;
        case (state_q)
            ST_CPU_ACC: state_d = ST_CPU_CAP;
            ST_SPI_ACC: state_d = ST_SPI_CAP;
            default: begin
                if (is_dispatch_state(state_q)) begin
                    if (cpu_go) begin
                        state_d = ST_CPU_ACC;
                    end else if (spi_go) begin
                        state_d = ST_SPI_ACC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (state_d == ST_CPU_ACC) begin
            cpu_pend_d = 1'b0;
        end else if (cpu_set) begin
            cpu_pend_d = 1'b1;
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        spi_ack  = 1'b0;
        case (state_q)
            ST_CPU_ACC: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_wdata;
                ram_we   = cpu_we & ~wp_hit;
            end
            ST_CPU_CAP: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_wdata;
            end
            ST_SPI_ACC: begin
                ram_addr = h_addr;
                ram_din  = h_wdata;
                ram_we   = h_we;
            end
            ST_SPI_CAP: begin
                ram_addr = h_addr;
                ram_din  = h_wdata;
                spi_ack  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        err_d               = err_q;
        err_d[ERR_CPU_OVR]  = err_q[ERR_CPU_OVR] | cpu_ovr;
        err_d[ERR_SPI_DROP] = err_q[ERR_SPI_DROP] | spi_drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cpu_pend_q  <= 1'b0;
            cpu_rdata_q <= '0;
            spi_rdata_q <= '0;
            err_q       <= '0;
        end else begin
            state_q    <= state_d;
            cpu_pend_q <= cpu_pend_d;
            err_q      <= err_d;
            if ((state_q == ST_CPU_CAP) && !cpu_we) begin
                cpu_rdata_q <= ram_dout;
            end
            if ((state_q == ST_SPI_CAP) && !h_we) begin
                spi_rdata_q <= ram_dout;
            end
        end
    end

    // Read data is forwarded during the ack cycle so it is valid alongside spi_ack.
    assign spi_rdata = (spi_clr && !h_we) ? ram_dout : spi_rdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign spi_busy  = spi_pend;
    assign err       = err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural dpram port A model.
// SPI transactions are scoreboarded; CPU reads are checked at their fixed latency.
module tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cpu_clken = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_rdata;
    logic          halt = 1'b0;
    logic          spi_req = 1'b0;
    logic          spi_we = 1'b0;
    logic [AW-1:0] spi_addr = '0;
    logic [DW-1:0] spi_wdata = '0;
    logic          spi_busy;
    logic          spi_ack;
    logic [DW-1:0] spi_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [1:0]    err;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .WP_BASE (16'hC000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_clken (cpu_clken),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .halt      (halt),
        .spi_req   (spi_req),
        .spi_we    (spi_we),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_busy  (spi_busy),
        .spi_ack   (spi_ack),
        .spi_rdata (spi_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .err       (err)
    );

    // dpram port A model with a backdoor preload path
    logic [DW-1:0] mem [0:65535];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else if (bd_we) mem[bd_addr] <= bd_data;
        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int we_cnt = 0;
    always @(negedge clk) if (ram_we) we_cnt <= we_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } spi_exp_t;

    spi_exp_t sq[$];

    always @(negedge clk) begin
        spi_exp_t e;
        if (spi_ack) begin
            if (sq.size() == 0) begin
                chk("spi_ack_unexpected", 32'd1, 32'd0);
            end else begin
                e = sq.pop_front();
                chk("spi_ack_cycle", cyc, e.due);
                if (e.we) chk("spi_wr_mem", {24'd0, mem[e.addr]}, {24'd0, e.data});
                else      chk("spi_rdata", {24'd0, spi_rdata}, {24'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
    endtask

    // Drive a one-cycle SPI request; ack expected due_off cycles later.
    task automatic spi_pulse(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int due_off);
        spi_exp_t e;
        spi_req   = 1'b1;
        spi_we    = we;
        spi_addr  = a;
        spi_wdata = d;
        e.we   = we;
        e.addr = a;
        e.data = d;
        e.due  = cyc + due_off;
        sq.push_back(e);
        tick();
        spi_req = 1'b0;
    endtask

    task automatic cpu_strobe(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
        cpu_clken = 1'b1;
        cpu_addr  = a;
        cpu_we    = we;
        cpu_wdata = d;
        tick();
        cpu_clken = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sq.size() != 0; i++) tick();
        chk("spi_drain", sq.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_addr"}, {16'd0, ram_addr}, 32'd0);
        chk({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        chk({tag, "_ram_din"}, {24'd0, ram_din}, 32'd0);
        chk({tag, "_spi_ack"}, {31'd0, spi_ack}, 32'd0);
        chk({tag, "_spi_busy"}, {31'd0, spi_busy}, 32'd0);
        chk({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 32'd0);
        chk({tag, "_spi_rdata"}, {24'd0, spi_rdata}, 32'd0);
        chk({tag, "_err"}, {30'd0, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int we0;
        logic [DW-1:0] wp_exp;

        // reset state
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // CPU read on an idle arbiter
        bd_write(16'h1234, 8'h5A);
        tick();
        we0 = we_cnt;
        cpu_strobe(16'h1234, 1'b0, 8'h00);
        @(negedge clk);
        chk("cpu_acc_addr", {16'd0, ram_addr}, 32'h1234);
        chk("cpu_acc_we", {31'd0, ram_we}, 32'd0);
        tick();
        @(negedge clk);
        chk("cpu_rd_early", {24'd0, cpu_rdata}, 32'h00);
        tick();
        @(negedge clk);
        chk("cpu_rd_idle", {24'd0, cpu_rdata}, 32'h5A);
        chk("cpu_rd_no_we", we_cnt - we0, 0);

        // SPI write then read back
        tick();
        chk("spi_busy_before", {31'd0, spi_busy}, 32'd0);
        spi_pulse(1'b1, 16'h0400, 8'hA7, 2);
        @(negedge clk);
        chk("spi_busy_pend", {31'd0, spi_busy}, 32'd1);
        wait_idle();
        @(negedge clk);
        chk("spi_busy_after", {31'd0, spi_busy}, 32'd0);
        tick();
        spi_pulse(1'b0, 16'h0400, 8'hA7, 2);
        wait_idle();

        // CPU and SPI strobes in the same cycle
        bd_write(16'h2000, 8'h11);
        bd_write(16'h3000, 8'h22);
        tick();
        cpu_clken = 1'b1;
        cpu_addr  = 16'h3000;
        cpu_we    = 1'b0;
        spi_pulse(1'b0, 16'h2000, 8'h11, 4);
        cpu_clken = 1'b0;
        @(negedge clk);
        chk("coll_cpu_addr", {16'd0, ram_addr}, 32'h3000);
        tick();
        tick();
        @(negedge clk);
        chk("coll_cpu_rdata", {24'd0, cpu_rdata}, 32'h22);
        chk("coll_spi_addr", {16'd0, ram_addr}, 32'h2000);
        wait_idle();

        // halt: CPU strobes ignored, SPI writes every 2 cycles
        bd_write(16'h5555, 8'h77);
        halt = 1'b1;
        tick();
        fork
            begin
                cpu_addr  = 16'h5555;
                cpu_we    = 1'b1;
                cpu_wdata = 8'hEE;
                for (int k = 0; k < 2; k++) begin
                    cpu_clken = 1'b1;
                    tick();
                    cpu_clken = 1'b0;
                    repeat (24) tick();
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    spi_pulse(1'b1, 16'h0500 + 16'(i), 8'h30 + 8'(i), 2);
                    tick();
                end
            end
        join
        wait_idle();
        chk("halt_cpu_no_write", {24'd0, mem[16'h5555]}, 32'h77);
        chk("halt_err", {30'd0, err}, 32'd0);

        // second SPI request while one is pending is dropped
        bd_write(16'h0601, 8'h00);
        tick();
        spi_pulse(1'b1, 16'h0600, 8'h99, 2);
        spi_req   = 1'b1;
        spi_we    = 1'b1;
        spi_addr  = 16'h0601;
        spi_wdata = 8'h98;
        tick();
        spi_req = 1'b0;
        wait_idle();
        chk("drop_err", {30'd0, err}, 32'h1);
        chk("drop_not_written", {24'd0, mem[16'h0601]}, 32'h00);
        halt = 1'b0;

        // CPU strobe while CPU still pending behind an SPI access
        tick();
        spi_pulse(1'b1, 16'h0700, 8'h42, 2);
        cpu_addr  = 16'h0700;
        cpu_we    = 1'b0;
        cpu_clken = 1'b1;
        tick();
        tick();
        cpu_clken = 1'b0;
        @(negedge clk);
        chk("ovr_cpu_addr", {16'd0, ram_addr}, 32'h0700);
        chk("ovr_cpu_we", {31'd0, ram_we}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("ovr_cpu_rdata", {24'd0, cpu_rdata}, 32'h42);
        chk("ovr_err", {30'd0, err}, 32'h3);
        wait_idle();

        // write protection of the ROM area
        bd_write(16'hC010, 8'h00);
        bd_write(16'hBFFF, 8'h00);
        tick();
`ifdef RAM_WP_EN
        wp_exp = 8'h00;
`else
        wp_exp = 8'hFF;
`endif
        cpu_strobe(16'hC010, 1'b1, 8'hFF);
        repeat (4) tick();
        chk("wp_cpu_c010", {24'd0, mem[16'hC010]}, {24'd0, wp_exp});
        cpu_strobe(16'hBFFF, 1'b1, 8'hFF);
        repeat (4) tick();
        chk("wp_cpu_bfff", {24'd0, mem[16'hBFFF]}, 32'hFF);
        spi_pulse(1'b1, 16'hC010, 8'h5C, 2);
        wait_idle();
        cpu_we = 1'b0;

        // reset in the middle of an SPI access
        tick();
        spi_req   = 1'b1;
        spi_we    = 1'b1;
        spi_addr  = 16'h0800;
        spi_wdata = 8'h66;
        tick();
        spi_req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) tick();
        reset_n = 1'b1;
        bd_write(16'h0ABC, 8'h3C);
        tick();
        cpu_strobe(16'h0ABC, 1'b0, 8'h00);
        tick();
        @(negedge clk);
        chk("post_reset_rd_early", {24'd0, cpu_rdata}, 32'h00);
        tick();
        @(negedge clk);
        chk("post_reset_rd", {24'd0, cpu_rdata}, 32'h3C);
        repeat (4) tick();
        chk("sq_empty_end", sq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
